// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR generator and its stream checker.
//   LFSR_W      : width of the LFSR state
//   LFSR_SEED   : generator start value
//   chk_state_t : checker FSM state
//   lfsr_next() : the one recurrence both generator and checker must agree on
package lfsr_pkg;

    localparam int LFSR_W = 4;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 4'b0001;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // The all-zero state maps to itself (lockup), so it is never a legal sample.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
        return {x[2:0], x[1] ^ x[3]};
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Sample/status bundle between an LFSR stream source and lfsr_checker.
//   data_i      : LFSR state sample under check
//   valid_i     : data_i is a new sample this cycle
//   clear_i     : synchronous clear of err_count_o
//   locked_o    : checker is locked
//   error_o     : one-cycle mismatch pulse
//   err_count_o : saturating mismatch count
// master = stream source / status reader, slave = checker.
interface lfsr_checker_if #(
    parameter int ERR_CNT_W = 16
);
    import lfsr_pkg::*;

    logic [LFSR_W-1:0]    data_i;
    logic                 valid_i;
    logic                 clear_i;
    logic                 locked_o;
    logic                 error_o;
    logic [ERR_CNT_W-1:0] err_count_o;

    modport master (
        output data_i, valid_i, clear_i,
        input  locked_o, error_o, err_count_o
    );

    modport slave (
        input  data_i, valid_i, clear_i,
        output locked_o, error_o, err_count_o
    );

endinterface

// File: rtl/lfsr_checker.sv
// LFSR stream checker. Locks after LOCK_COUNT+1 consecutive samples that follow
// lfsr_next(), then flywheels a local reference, pulses error_o for every
// mismatch and keeps a saturating error count. LOSS_COUNT consecutive misses
// while locked drop back to SEARCH.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : lfsr_checker_if.slave (data_i/valid_i/clear_i in, status out)
// The interface instance must use the same ERR_CNT_W as this module.
//
// state  | meaning
// SEARCH | building a run of consecutive correct samples, no errors reported
// LOCKED | flywheel reference running, mismatches counted
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_CNT_W  = 16
) (
    input logic           clk,
    input logic           reset,
    lfsr_checker_if.slave bus
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 2);
    localparam int MISS_W  = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;

    localparam logic [MATCH_W-1:0]   MATCH_ONE  = MATCH_W'(1);
    // match_cnt value whose next correct sample completes the lock run
    localparam logic [MATCH_W-1:0]   MATCH_LAST = MATCH_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]    MISS_ONE   = MISS_W'(1);
    localparam logic [MISS_W-1:0]    MISS_LAST  = MISS_W'(LOSS_COUNT - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE    = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

    chk_state_t           state;
    logic [LFSR_W-1:0]    ref_q;
    logic [MATCH_W-1:0]   match_cnt;
    logic [MISS_W-1:0]    miss_cnt;
    logic                 locked_q;
    logic                 error_q;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [LFSR_W-1:0]    expected;

    assign expected = lfsr_next(ref_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            ref_q     <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            error_q <= 1'b0;
            if (bus.valid_i) begin
                case (state)
                    SEARCH: begin
                        if (bus.data_i == '0) begin
                            match_cnt <= '0;
                        end else if (match_cnt == '0 || bus.data_i != expected) begin
                            // seed, or reseed on a broken run
                            ref_q     <= bus.data_i;
                            match_cnt <= MATCH_ONE;
                        end else begin
                            ref_q <= bus.data_i;
                            if (match_cnt == MATCH_LAST) begin
                                state     <= LOCKED;
                                locked_q  <= 1'b1;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + MATCH_ONE;
                            end
                        end
                    end
                    LOCKED: begin
                        if (bus.data_i == expected) begin
                            ref_q    <= bus.data_i;
                            miss_cnt <= '0;
                        end else begin
                            // flywheel: advance on our own prediction, not on bad data
                            error_q <= 1'b1;
                            ref_q   <= expected;
                            if (err_cnt != ERR_MAX) begin
                                err_cnt <= err_cnt + ERR_ONE;
                            end
                            if (miss_cnt == MISS_LAST) begin
                                state     <= SEARCH;
                                locked_q  <= 1'b0;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_ONE;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
            // clear takes priority over a same-cycle increment
            if (bus.clear_i) begin
                err_cnt <= '0;
            end
        end
    end

    assign bus.locked_o    = locked_q;
    assign bus.error_o     = error_q;
    assign bus.err_count_o = err_cnt;

endmodule
